// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit add/subtract split into STAGES registered ripple-carry slices.
// Optional `define PRA_SATURATE_EN adds i_sat, clamping the result on signed overflow.

module pra_slice #(
    parameter int S = 8
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] s,
    output logic         cout,
    output logic         ovf
);
    logic [S:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < S; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[S];
    // carry into the slice MSB vs carry out of it; only meaningful on the top slice
    assign ovf  = c[S] ^ c[S-1];
endmodule

module pipelined_ripple_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
`ifdef PRA_SATURATE_EN
    input  logic             i_sat,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    localparam int S  = WIDTH / STAGES;
    localparam int NQ = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int L  = STAGES - 1;

    logic             stall, adv, accept;
    logic [STAGES:1]  vld_pipe;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // stage k inputs: from the ports for k = 0, otherwise from the skew registers of k-1
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [WIDTH-1:0]  a_in   [STAGES];
    logic [WIDTH-1:0]  b_in   [STAGES];
    logic [WIDTH-1:0]  sum_in [STAGES];
    logic [WIDTH-1:0]  sum_nx [STAGES];
    logic [S-1:0]      s_c    [STAGES];
    logic              cout_c [STAGES];
    logic              ovf_c  [STAGES];

    logic [WIDTH-1:0]  a_q [NQ];
    logic [WIDTH-1:0]  b_q [NQ];
    logic [WIDTH-1:0]  s_q [NQ];
    logic [NQ-1:0]     c_q;

    logic [WIDTH-1:0]  res;

    assign o_valid = vld_pipe[STAGES];
    assign stall   = o_valid & ~i_ready;
    assign adv     = ~stall;
    assign o_ready = adv;
    assign accept  = i_valid & adv;
    assign b_eff   = i_sub ? ~i_b : i_b;
    assign cin_eff = i_cin ^ i_sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign v_in[k]   = accept;
            assign c_in[k]   = cin_eff;
            assign a_in[k]   = i_a;
            assign b_in[k]   = b_eff;
            assign sum_in[k] = '0;
        end else begin : g_body
            assign v_in[k]   = vld_pipe[k];
            assign c_in[k]   = c_q[k-1];
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign sum_in[k] = s_q[k-1];
        end

        pra_slice #(.S(S)) u_slice (
            .a    (a_in[k][k*S +: S]),
            .b    (b_in[k][k*S +: S]),
            .cin  (c_in[k]),
            .s    (s_c[k]),
            .cout (cout_c[k]),
            .ovf  (ovf_c[k])
        );

        assign sum_nx[k] = (sum_in[k] & ~(WIDTH'({S{1'b1}}) << (k*S)))
                         | (WIDTH'(s_c[k]) << (k*S));
    end

`ifdef PRA_SATURATE_EN
    logic [STAGES-1:0] sat_in;
    logic [NQ-1:0]     sat_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_sat
        if (k == 0) begin : g_head
            assign sat_in[k] = i_sat;
        end else begin : g_body
            assign sat_in[k] = sat_q[k-1];
        end
    end

    // overflow direction follows the sign of A (B has already been conditioned for sub)
    always_comb begin
        res = sum_nx[L];
        if (sat_in[L] && ovf_c[L])
            res = a_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    assign res = sum_nx[L];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            c_q      <= '0;
            o_sum    <= '0;
            o_cout   <= 1'b0;
            o_ovf    <= 1'b0;
            for (int k = 0; k < NQ; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            vld_pipe[1] <= accept;
            for (int k = 2; k <= STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
            // data regs only load behind a valid token so an empty pipe keeps its last result
            for (int k = 0; k < STAGES - 1; k++) begin
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= sum_nx[k];
                    c_q[k] <= cout_c[k];
                end
            end
            if (v_in[L]) begin
                o_sum  <= res;
                o_cout <= cout_c[L];
                o_ovf  <= ovf_c[L];
            end
        end
    end

`ifdef PRA_SATURATE_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_q <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES - 1; k++)
                if (v_in[k]) sat_q[k] <= sat_in[k];
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder (WIDTH=32, STAGES=4), directed vectors.
// Build with +define+PRA_SATURATE_EN to also exercise the saturating path.

module tb_pipelined_ripple_adder;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         i_clk, i_rst_n, i_valid, o_ready, i_cin, i_sub, o_valid, i_ready, o_cout, o_ovf;
    logic [W-1:0] i_a, i_b, o_sum;
`ifdef PRA_SATURATE_EN
    logic         i_sat;
`endif

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   stall_cycles = 0;

    pipelined_ripple_adder #(.WIDTH(W), .STAGES(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .i_sub   (i_sub),
`ifdef PRA_SATURATE_EN
        .i_sat   (i_sat),
`endif
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic sat,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf);
        logic rdy;
        bit   done;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_cin   = cin;
        i_sub   = sub;
`ifdef PRA_SATURATE_EN
        i_sat   = sat;
`else
        if (sat) $display("note: sat request ignored in this build");
`endif
        exp_q.push_back('{sum: esum, cout: ecout, ovf: eovf});
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge i_clk);
            rdy = o_ready;
            @(posedge i_clk);
            #1;
            done = rdy;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got o_ready=0 for 20 cycles, expected acceptance");
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge i_clk);
            done = (exp_q.size() == 0) && !o_valid;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
        end
        @(posedge i_clk);
        #1;
    endtask

    // monitor: pops the scoreboard on every handshake, checks o_ready and stall stability
    initial begin
        exp_t              e;
        logic              was_stall;
        logic [W+1:0]      prev;
        was_stall = 1'b0;
        prev      = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                chk("o_ready", {31'd0, o_ready}, {31'd0, !(o_valid && !i_ready)});
                if (was_stall)
                    chk("stall_stable_sum", o_sum, prev[W+1:2]);
                if (was_stall)
                    chk("stall_stable_flags", {30'd0, o_cout, o_ovf}, {30'd0, prev[1:0]});
                if (o_valid && !i_ready)
                    stall_cycles++;
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got 0x%08h, expected no output", o_sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sum", o_sum, e.sum);
                        chk("cout_ovf", {30'd0, o_cout, o_ovf}, {30'd0, e.cout, e.ovf});
                    end
                end
                was_stall = o_valid && !i_ready;
                prev      = {o_sum, o_cout, o_ovf};
            end else begin
                was_stall = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got no completion, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a = '0; i_b = '0; i_cin = 1'b0; i_sub = 1'b0;
`ifdef PRA_SATURATE_EN
        i_sat = 1'b0;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_sum", o_sum, 32'd0);
        chk("rst_flags", {30'd0, o_cout, o_ovf}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // latency: accepted at one edge, valid after the fourth following edge
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge i_clk);
            chk($sformatf("latency_c%0d", i), {31'd0, o_valid}, (i == 4) ? 32'd1 : 32'd0);
        end
        @(posedge i_clk);
        #1;

        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        send(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef PRA_SATURATE_EN
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
        send(32'h7FFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
`endif
        wait_drain();

        // back-to-back stream with a three-cycle downstream stall
        stall_cycles = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'(i), 32'(16 * i), 1'b0, 1'b0, 1'b0, 32'(17 * i), 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge i_clk);
                #1 i_ready = 1'b0;
                repeat (3) @(posedge i_clk);
                #1 i_ready = 1'b1;
            end
        join
        wait_drain();
        chk("stall_cycles", 32'(stall_cycles), 32'd3);
        chk("empty_hold_sum", o_sum, 32'h0000_0077);
        chk("empty_valid", {31'd0, o_valid}, 32'd0);

        // reset with three operations in flight
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        send(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
        send(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'h0000_0006, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("inflight_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("inflight_rst_sum", o_sum, 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined successor to the team's 32-bit combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple-carry slices of WIDTH/STAGES bits each, with one register stage per slice.
- Carry propagates slice-to-slice across cycles; operands and partial sums are skewed accordingly.
- Provides carry-in, subtract mode, carry-out and signed overflow, behind a valid/ready handshake with backpressure.
- Sits in the datapath wherever a wide adder must close timing at high clock rates.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices/registers; 1 <= STAGES <= WIDTH.

Ports:
- i_clk  input  1  clock; all flops rising-edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input operands valid.
- o_ready  output  1  block accepts input this cycle.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_cin  input  1  carry-in (add) / borrow-in (sub).
- i_sub  input  1  1 = A - B, 0 = A + B.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_sum  output  WIDTH  result.
- o_cout  output  1  carry out of MSB (sub: 1 = no borrow).
- o_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync-safe deassert by design):
  - o_valid = 0, o_sum = 0, o_cout = 0, o_ovf = 0.
  - All stage valid bits, skew registers and inter-slice carry registers = 0.
  - In-flight operations are discarded; no stale result appears after reset release.
- Arithmetic:
  - Effective B = i_sub ? ~i_b : i_b.
  - Effective carry-in = i_cin ^ i_sub.
  - Add with cin = 1 gives A + B + 1. Sub with cin = 0 gives A - B; sub with cin = 1 gives A - B - 1.
  - o_sum = (A + effB + effcin) mod 2^WIDTH.
  - o_cout = carry out of bit WIDTH-1.
  - o_ovf = carry into MSB XOR carry out of MSB.
- Pipeline:
  - Stage k (0..STAGES-1) computes bits [k*S +: S], where S = WIDTH/STAGES, with a bit-level ripple chain.
  - Stage k takes the carry registered from stage k-1; stage 0 takes the effective carry-in.
  - Upper operand slices are delayed k cycles; finished lower slices are carried forward in skew registers.
- Latency: exactly STAGES cycles from an accepted input (i_valid & o_ready) to o_valid, when not stalled. Throughput is 1 result per cycle.
- Handshake:
  - stall = o_valid & ~i_ready.
  - o_ready = ~stall (combinational).
  - While stall = 1, every pipeline register holds, and o_sum/o_cout/o_ovf stay stable.
  - An input presented during a stall is not accepted; the source must hold it.
  - Bubbles are not collapsed: the pipeline is a fixed shift register gated by ~stall.
- Empty pipeline: o_valid = 0, and output data holds its last value.
- Simultaneous i_valid and result pop: accepted when ~stall; the pipeline shifts by one.
- STAGES = 1: a single registered WIDTH-bit ripple adder, latency 1.
- Operand changes while i_valid = 0 have no effect on outputs.

Optional Feature:
- Macro: PRA_SATURATE_EN.
- Defined:
  - Adds input port i_sat (1 bit), sampled with the operands and carried down the pipeline.
  - When i_sat = 1 and signed overflow occurs, o_sum clamps to 0x7F..F (positive overflow: sign of A = 0) or 0x80..0 (negative overflow).
  - o_ovf still reports 1.
  - Clamping happens in the final stage with no added latency.
- Not defined: no i_sat port; the result always wraps.

Test Plan:
- WIDTH = 32, STAGES = 4; A = 0xFFFFFFFF, B = 0x00000001, cin = 0, sub = 0, i_ready = 1 -> after 4 cycles o_valid = 1, o_sum = 0x00000000, o_cout = 1, o_ovf = 0.
- A = 0x00000005, B = 0x00000007, sub = 1, cin = 0 -> o_sum = 0xFFFFFFFE, o_cout = 0, o_ovf = 0. Same operands with cin = 1 -> o_sum = 0xFFFFFFFD.
- A = 0x7FFFFFFF, B = 0x00000001, add -> o_sum = 0x80000000, o_ovf = 1, o_cout = 0. A = 0x80000000, B = 0x00000001, sub -> o_sum = 0x7FFFFFFF, o_ovf = 1, o_cout = 1.
- Back-to-back stream of 8 operations (A = i, B = 0x10*i); i_ready low for 3 cycles mid-stream -> o_ready low exactly while o_valid & ~i_ready, outputs stable during the stall, all 8 results in order with no loss or duplication.
- Assert i_rst_n low with 3 operations in flight -> o_valid = 0 immediately. After release, with no new inputs, o_valid stays 0.
- With PRA_SATURATE_EN: A = 0x7FFFFFFF, B = 0x00000001, i_sat = 1 -> o_sum = 0x7FFFFFFF, o_ovf = 1. A = 0x80000000, B = 0x00000001, sub, i_sat = 1 -> o_sum = 0x80000000, o_ovf = 1.
